// File: rtl/pifo_calendar_pop_ctrl.sv
// Dequeue controller for the calendar PIFO: pops the due head atom into a 2-entry FWFT buffer (data on m_axis next cycle);
// pops stall while the buffer is full and not draining. PIFO_POP_STATS_EN adds saturating pop/blocked counters.
module pifo_calendar_pop_ctrl #(
    parameter int ELEMENT_WIDTH       = 32,
    parameter int ELEMENT_RANK_WIDTH  = 19,
    parameter int RANK_START_POS      = 12,
    parameter int RANK_END_POS        = 30,
    parameter int PIFO_INFO_VALID_POS = 31,
    parameter int TICK_DIV            = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_enable,
    input  logic                          in_flush,
    input  logic [ELEMENT_WIDTH-1:0]      in_head_element,
    input  logic                          in_ctl_insert,
    input  logic                          in_cpu_req,
    output logic                          out_ctl_pop,
    output logic                          out_cpu_insert,
    output logic                          out_cpu_stall,
    output logic [ELEMENT_RANK_WIDTH-1:0] out_cur_time,
    output logic [ELEMENT_WIDTH-1:0]      m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          out_busy
`ifdef PIFO_POP_STATS_EN
    ,
    output logic [31:0]                   out_stat_pops,
    output logic [31:0]                   out_stat_blocked
`endif
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    state_t                          state_q, state_d;
    logic                            busy_q;
    logic [TW-1:0]                   tick_q, tick_d;
    logic [ELEMENT_RANK_WIDTH-1:0]   cur_time_q, cur_time_d;
    logic [ELEMENT_WIDTH-1:0]        buf_q [2];
    logic                            rd_ptr_q, wr_ptr_q;
    logic [1:0]                      count_q, count_d;

    logic                            head_vld;
    logic [ELEMENT_RANK_WIDTH-1:0]   head_rank;
    logic [ELEMENT_RANK_WIDTH-1:0]   age;
    logic                            eligible;
    logic                            deq;
    logic                            room;
    logic                            cpu_grant;
    logic                            pop_rank_ok;
    logic                            pop;

    assign head_vld  = in_head_element[PIFO_INFO_VALID_POS];
    assign head_rank = in_head_element[RANK_END_POS:RANK_START_POS];
    // Modular age: a head less than half the time ring behind "now" counts as due.
    assign age       = cur_time_q - head_rank;
    assign eligible  = head_vld & ~age[ELEMENT_RANK_WIDTH-1];

    assign deq         = m_axis_tvalid & m_axis_tready;
    assign room        = (count_q - {1'b0, deq}) < 2'd2;
    assign cpu_grant   = in_cpu_req & ~in_ctl_insert;
    assign pop_rank_ok = ((state_q == RUN) & eligible) | (state_q == FLUSH);
    assign pop         = room & head_vld & ~cpu_grant & pop_rank_ok;

    assign out_ctl_pop    = pop;
    assign out_cpu_insert = cpu_grant;
    assign out_cpu_stall  = in_cpu_req & in_ctl_insert;
    assign out_cur_time   = cur_time_q;
    assign m_axis_tvalid  = (count_q != 2'd0);
    assign m_axis_tdata   = buf_q[rd_ptr_q];
    assign out_busy       = busy_q;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        cur_time_d = cur_time_q;
        count_d    = count_q + {1'b0, pop} - {1'b0, deq};
        case (state_q)
            IDLE: begin
                if (in_flush) begin
                    state_d = FLUSH;
                end else if (in_enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick_q == TICK_LAST) begin
                    tick_d     = '0;
                    cur_time_d = cur_time_q + 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
                if (in_flush) begin
                    state_d = FLUSH;
                end else if (!in_enable) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (!head_vld) begin
                    state_d = in_enable ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            tick_q     <= '0;
            cur_time_q <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            busy_q     <= (state_d != IDLE);
            tick_q     <= tick_d;
            cur_time_q <= cur_time_d;
            count_q    <= count_d;
            // Writes always target the slot not being presented, so a stalled beat stays put.
            if (pop) begin
                buf_q[wr_ptr_q] <= in_head_element;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

`ifdef PIFO_POP_STATS_EN
    logic [31:0] stat_pops_q;
    logic [31:0] stat_blocked_q;
    logic        blocked;

    assign blocked = head_vld & pop_rank_ok & ~room;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pops_q    <= '0;
            stat_blocked_q <= '0;
        end else begin
            if (pop && (stat_pops_q != '1)) begin
                stat_pops_q <= stat_pops_q + 32'd1;
            end
            if (blocked && (stat_blocked_q != '1)) begin
                stat_blocked_q <= stat_blocked_q + 32'd1;
            end
        end
    end

    assign out_stat_pops    = stat_pops_q;
    assign out_stat_blocked = stat_blocked_q;
`endif

endmodule
